// File: rtl/shifter_arb_pkg.sv
// Shared types and helpers for the shifter arbiter.
package shifter_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        RESP  = 2'd2
    } arb_state_e;

    // Index width that never collapses to zero bits for a single requester.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? int'($clog2(n)) : 1;
    endfunction

endpackage

// File: rtl/barrel_shifter.sv
// Combinational left barrel shifter, zero-fill, with a widened result.
module barrel_shifter #(
    parameter int unsigned InputDataWidth  = 11,
    parameter int unsigned OutputDataWidth = 22,
    parameter int unsigned MaxShift        = 11,
    localparam int unsigned ShiftW         = $clog2(MaxShift + 1)
) (
    input  logic [InputDataWidth-1:0]  data_i,
    input  logic [ShiftW-1:0]          shift_i,
    output logic [OutputDataWidth-1:0] data_o
);

    // Widen before shifting so no operand bits fall off the top.
    always_comb begin
        data_o = OutputDataWidth'(data_i) << shift_i;
    end

endmodule

// File: rtl/shifter_arbiter.sv
// Round-robin arbiter sharing one barrel shifter between NumReq requesters,
// with a registered, id-tagged response and clamping of oversize shifts.
module shifter_arbiter
    import shifter_arb_pkg::*;
#(
    parameter int unsigned InputDataWidth  = 11,
    parameter int unsigned OutputDataWidth = 22,
    parameter int unsigned MaxShift        = 11,
    parameter int unsigned NumReq          = 2,
    localparam int unsigned ShiftW         = $clog2(MaxShift + 1),
    localparam int unsigned IdW            = clog2_min1(NumReq)
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NumReq-1:0]                req_valid_i,
    output logic [NumReq-1:0]                req_ready_o,
    input  logic [NumReq*InputDataWidth-1:0] req_data_i,
    input  logic [NumReq*ShiftW-1:0]         req_shift_i,
    output logic                             rsp_valid_o,
    input  logic                             rsp_ready_i,
    output logic [OutputDataWidth-1:0]       rsp_data_o,
    output logic [IdW-1:0]                   rsp_id_o,
    output logic                             rsp_clamp_o
);

    localparam logic [ShiftW-1:0] MaxShiftW = ShiftW'(MaxShift);
    localparam logic [IdW-1:0]    LastId    = IdW'(NumReq - 1);

    arb_state_e                 state_q, state_d;
    logic [IdW-1:0]             rr_ptr_q, rr_ptr_d;
    logic [InputDataWidth-1:0]  data_q, data_d;
    logic [ShiftW-1:0]          shift_q, shift_d;
    logic                       clamp_q, clamp_d;
    logic [IdW-1:0]             id_q, id_d;
    logic                       rsp_valid_q, rsp_valid_d;
    logic [OutputDataWidth-1:0] rsp_data_q, rsp_data_d;
    logic [IdW-1:0]             rsp_id_q, rsp_id_d;
    logic                       rsp_clamp_q, rsp_clamp_d;

    logic                       grant_valid;
    logic [IdW-1:0]             grant_id;
    int unsigned                cand;
    logic [InputDataWidth-1:0]  req_data_sel;
    logic [ShiftW-1:0]          req_shift_sel;
    logic                       req_clamp;
    logic [OutputDataWidth-1:0] shifted;

    // Round-robin pick: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        cand        = 0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            cand = (32'(rr_ptr_q) + i) % NumReq;
            if (!grant_valid && req_valid_i[IdW'(cand)]) begin
                grant_valid = 1'b1;
                grant_id    = IdW'(cand);
            end
        end
    end

    // Operand of the current winner and its clamp decision.
    always_comb begin
        req_data_sel  = req_data_i[grant_id*InputDataWidth +: InputDataWidth];
        req_shift_sel = req_shift_i[grant_id*ShiftW +: ShiftW];
        req_clamp     = req_shift_sel > MaxShiftW;
    end

    // Shifter sees only the latched operand, never the live request ports.
    barrel_shifter #(
        .InputDataWidth (InputDataWidth),
        .OutputDataWidth(OutputDataWidth),
        .MaxShift       (MaxShift)
    ) u_barrel_shifter (
        .data_i (data_q),
        .shift_i(shift_q),
        .data_o (shifted)
    );

    // FSM next-state, operand capture, response staging and request accept.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        data_d      = data_q;
        shift_d     = shift_q;
        clamp_d     = clamp_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        rsp_clamp_d = rsp_clamp_q;
        req_ready_o = '0;

        unique case (state_q)
            IDLE: begin
                if (grant_valid && !rst_i) begin
                    req_ready_o[grant_id] = 1'b1;
                    data_d   = req_data_sel;
                    shift_d  = req_clamp ? MaxShiftW : req_shift_sel;
                    clamp_d  = req_clamp;
                    id_d     = grant_id;
                    rr_ptr_d = (grant_id == LastId) ? '0 : grant_id + IdW'(1);
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                rsp_data_d  = shifted;
                rsp_id_d    = id_q;
                rsp_clamp_d = clamp_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_valid_q && rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; reset drops any in-flight request.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            data_q      <= '0;
            shift_q     <= '0;
            clamp_q     <= 1'b0;
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            rsp_clamp_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            data_q      <= data_d;
            shift_q     <= shift_d;
            clamp_q     <= clamp_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
            rsp_clamp_q <= rsp_clamp_d;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_id_o    = rsp_id_q;
    assign rsp_clamp_o = rsp_clamp_q;

endmodule

// File: tb/tb_shifter_arbiter.sv
// Bench for shifter_arbiter: directed scenarios plus random traffic, all
// checked against a transaction-level model of the arbiter.
module tb_shifter_arbiter;

    localparam int unsigned IDW = 11;
    localparam int unsigned ODW = 22;
    localparam int unsigned MS  = 11;
    localparam int unsigned NR  = 2;
    localparam int unsigned SW  = 4;
    localparam int unsigned IW  = 1;

    logic                clk = 1'b0;
    logic                rst;
    logic [NR-1:0]       req_valid;
    logic [NR-1:0]       req_ready;
    logic [NR*IDW-1:0]   req_data;
    logic [NR*SW-1:0]    req_shift;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [ODW-1:0]      rsp_data;
    logic [IW-1:0]       rsp_id;
    logic                rsp_clamp;

    always #5 clk = ~clk;

    shifter_arbiter #(
        .InputDataWidth (IDW),
        .OutputDataWidth(ODW),
        .MaxShift       (MS),
        .NumReq         (NR)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .req_data_i (req_data),
        .req_shift_i(req_shift),
        .rsp_valid_o(rsp_valid),
        .rsp_ready_i(rsp_ready),
        .rsp_data_o (rsp_data),
        .rsp_id_o   (rsp_id),
        .rsp_clamp_o(rsp_clamp)
    );

    // Model: pending requests per requester, one outstanding transaction.
    bit             pend[NR];
    logic [IDW-1:0] pd[NR];
    logic [SW-1:0]  ps[NR];
    bit             busy;
    int             age;
    int             rr;
    logic [ODW-1:0] e_data;
    int             e_id;
    bit             e_clamp;
    bit             rdy_dir;

    int             n_cmp = 0;
    int             n_fail = 0;

    // Observed grants and accepted responses, for directed checks.
    int             gq[$];
    logic [ODW-1:0] rq_data[$];
    int             rq_id[$];
    bit             rq_clamp[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [ODW-1:0] ref_shift(input logic [IDW-1:0] d, input logic [SW-1:0] s);
        longint sh;
        sh = (s > MS) ? MS : longint'(s);
        return ODW'(longint'(d) * (longint'(1) << sh));
    endfunction

    task automatic clear_obs();
        gq.delete();
        rq_data.delete();
        rq_id.delete();
        rq_clamp.delete();
    endtask

    // One clock cycle: drive, compare against the model, advance the model.
    task automatic tick(input bit rnd);
        int g;
        bit done;
        for (int k = 0; k < NR; k++) begin
            if (!pend[k] && rnd && $urandom_range(0, 2) == 0) begin
                pend[k] = 1'b1;
                pd[k]   = IDW'($urandom);
                ps[k]   = SW'($urandom);
            end
        end
        for (int k = 0; k < NR; k++) begin
            req_valid[k]           = pend[k];
            req_data[k*IDW +: IDW] = pd[k];
            req_shift[k*SW +: SW]  = ps[k];
        end
        rsp_ready = rnd ? ($urandom_range(0, 3) != 0) : rdy_dir;
        #1;
        g = -1;
        if (!busy) begin
            for (int i = 0; i < NR; i++) begin
                if (g < 0 && pend[(rr + i) % NR]) g = (rr + i) % NR;
            end
        end
        check("req_ready", 64'(req_ready), (g >= 0) ? (64'd1 << g) : 64'd0);
        check("rsp_valid", 64'(rsp_valid), 64'(busy && age >= 2));
        if (busy && age >= 2) begin
            check("rsp_data", 64'(rsp_data), 64'(e_data));
            check("rsp_id", 64'(rsp_id), 64'(e_id));
            check("rsp_clamp", 64'(rsp_clamp), 64'(e_clamp));
        end
        for (int k = 0; k < NR; k++) if (req_ready[k]) gq.push_back(k);
        if (rsp_valid && rsp_ready) begin
            rq_data.push_back(rsp_data);
            rq_id.push_back(int'(rsp_id));
            rq_clamp.push_back(rsp_clamp);
        end
        done = busy && age >= 2 && rsp_ready;
        if (g >= 0) begin
            busy    = 1'b1;
            age     = 1;
            e_data  = ref_shift(pd[g], ps[g]);
            e_id    = g;
            e_clamp = ps[g] > MS;
            rr      = (g + 1) % NR;
            pend[g] = 1'b0;
        end else if (done) begin
            busy = 1'b0;
        end else if (busy) begin
            age++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        for (int k = 0; k < NR; k++) pend[k] = 1'b0;
        @(posedge clk);
        #1;
        busy = 1'b0;
        age  = 0;
        rr   = 0;
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_valid", 64'(rsp_valid), 64'd0);
        check("rst_data", 64'(rsp_data), 64'd0);
        check("rst_id", 64'(rsp_id), 64'd0);
        check("rst_clamp", 64'(rsp_clamp), 64'd0);
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_shift = '0;
        rsp_ready = 1'b0;
        rdy_dir   = 1'b1;
        busy      = 1'b0;
        age       = 0;
        rr        = 0;
        repeat (2) @(posedge clk);
        #1;

        // Single request, latency and result.
        do_reset();
        clear_obs();
        pend[0] = 1'b1; pd[0] = 11'd1200; ps[0] = 4'd3;
        rdy_dir = 1'b1;
        repeat (4) tick(1'b0);
        check("t1_ngrant", 64'(gq.size()), 64'd1);
        check("t1_grant", 64'((gq.size() > 0) ? gq[0] : -1), 64'd0);
        check("t1_data", 64'((rq_data.size() > 0) ? rq_data[0] : '1), 64'd9600);
        check("t1_id", 64'((rq_id.size() > 0) ? rq_id[0] : -1), 64'd0);

        // Simultaneous requests from reset: requester 0 wins first.
        do_reset();
        clear_obs();
        pend[0] = 1'b1; pd[0] = 11'd999;  ps[0] = 4'd5;
        pend[1] = 1'b1; pd[1] = 11'd2003; ps[1] = 4'd7;
        repeat (8) tick(1'b0);
        check("t2_nrsp", 64'(rq_data.size()), 64'd2);
        check("t2_data0", 64'((rq_data.size() > 0) ? rq_data[0] : '1), 64'd31968);
        check("t2_id0", 64'((rq_id.size() > 0) ? rq_id[0] : -1), 64'd0);
        check("t2_data1", 64'((rq_data.size() > 1) ? rq_data[1] : '1), 64'd256384);
        check("t2_id1", 64'((rq_id.size() > 1) ? rq_id[1] : -1), 64'd1);

        // Both held valid: grants alternate.
        clear_obs();
        pd[0] = 11'd100; ps[0] = 4'd1;
        pd[1] = 11'd200; ps[1] = 4'd2;
        repeat (18) begin
            pend[0] = 1'b1;
            pend[1] = 1'b1;
            tick(1'b0);
        end
        repeat (9) tick(1'b0);
        check("t3_ngrant", 64'(gq.size() >= 6), 64'd1);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("t3_grant%0d", i), 64'((gq.size() > i) ? gq[i] : -1), 64'(i % 2));
        end

        // Clamping boundary on requester 1.
        clear_obs();
        pend[1] = 1'b1; pd[1] = 11'd1; ps[1] = 4'd15;
        repeat (4) tick(1'b0);
        pend[1] = 1'b1; pd[1] = 11'd1; ps[1] = 4'd11;
        repeat (4) tick(1'b0);
        check("t4_data_c", 64'((rq_data.size() > 0) ? rq_data[0] : '1), 64'd2048);
        check("t4_clamp_c", 64'((rq_clamp.size() > 0) ? rq_clamp[0] : 1'b0), 64'd1);
        check("t4_id", 64'((rq_id.size() > 0) ? rq_id[0] : -1), 64'd1);
        check("t4_data_m", 64'((rq_data.size() > 1) ? rq_data[1] : '1), 64'd2048);
        check("t4_clamp_m", 64'((rq_clamp.size() > 1) ? rq_clamp[1] : 1'b1), 64'd0);

        // Response back-pressure with another request waiting.
        clear_obs();
        rdy_dir = 1'b0;
        pend[0] = 1'b1; pd[0] = 11'd5; ps[0] = 4'd2;
        repeat (2) tick(1'b0);
        pend[1] = 1'b1; pd[1] = 11'd7; ps[1] = 4'd0;
        repeat (5) tick(1'b0);
        check("t5_held", 64'(gq.size()), 64'd1);
        rdy_dir = 1'b1;
        repeat (5) tick(1'b0);
        check("t5_grant1", 64'((gq.size() > 1) ? gq[1] : -1), 64'd1);
        check("t5_data0", 64'((rq_data.size() > 0) ? rq_data[0] : '1), 64'd20);
        check("t5_data1", 64'((rq_data.size() > 1) ? rq_data[1] : '1), 64'd7);

        // Reset while the shifter stage holds a request.
        clear_obs();
        pend[0] = 1'b1; pd[0] = 11'd3; ps[0] = 4'd1;
        tick(1'b0);
        do_reset();
        repeat (4) tick(1'b0);
        check("t6_norsp", 64'(rq_data.size()), 64'd0);
        clear_obs();
        pend[0] = 1'b1; pd[0] = 11'd9;  ps[0] = 4'd4;
        pend[1] = 1'b1; pd[1] = 11'd10; ps[1] = 4'd6;
        repeat (6) tick(1'b0);
        check("t6_first", 64'((gq.size() > 0) ? gq[0] : -1), 64'd0);
        check("t6_second", 64'((gq.size() > 1) ? gq[1] : -1), 64'd1);

        // Random traffic and random response back-pressure.
        do_reset();
        repeat (400) tick(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
